// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// drain-counter sizing and the load-use hazard predicate.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StMemWait  = 2'd1,
        StIrqDrain = 2'd2,
        StIrqTake  = 2'd3
    } ctrl_state_e;

    localparam int unsigned DrainCyclesDefault = 2;
    localparam int unsigned DrainCntW          = 3;

    // A load in EX whose destination feeds either ID source must stall one cycle.
    function automatic logic load_use_hazard(
        input logic       mem_read,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt
    );
        return mem_read && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones.
module sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != {Width{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard / interrupt-entry controller. The interrupt drain path is
// built only when PIPE_HAZARD_CTRL_IRQ_EN is defined; otherwise irq is ignored.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = DrainCyclesDefault,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_rt,
    input  logic             EX_Branch_EN,
    input  logic             ext_stall,
    input  logic             irq,
    output logic             PC_hold,
    output logic             IFID_hold,
    output logic             IFID_flush,
    output logic             IDEX_flush,
    output logic             irq_ack,
    output logic             PC_irq_sel,
    output logic             EPC_from_branch,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       ctrl_state
);

`ifdef PIPE_HAZARD_CTRL_IRQ_EN
    localparam bit IrqEn = 1'b1;
`else
    localparam bit IrqEn = 1'b0;
`endif

    localparam logic [DrainCntW-1:0] DrainLoad = DrainCntW'(DRAIN_CYCLES);

    ctrl_state_e          state_q, state_d;
    logic [DrainCntW-1:0] drain_q, drain_d;
    logic                 epc_q, epc_d;
    logic                 irq_req;
    logic                 load_use;
    logic                 irq_take;

    assign irq_req  = IrqEn && irq;
    assign load_use = load_use_hazard(EX_MemRead, EX_rt, ID_rs, ID_rt);

    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        epc_d      = epc_q;
        PC_hold    = 1'b0;
        IFID_hold  = 1'b0;
        IFID_flush = 1'b0;
        IDEX_flush = 1'b0;
        irq_take   = 1'b0;

        unique case (state_q)
            StRun: begin
                if (ext_stall) begin
                    PC_hold   = 1'b1;
                    IFID_hold = 1'b1;
                    state_d   = StMemWait;
                end else begin
                    // A taken branch squashes the dependent instruction anyway.
                    if (EX_Branch_EN) begin
                        IFID_flush = 1'b1;
                        IDEX_flush = 1'b1;
                    end else if (load_use) begin
                        PC_hold    = 1'b1;
                        IFID_hold  = 1'b1;
                        IDEX_flush = 1'b1;
                    end
                    if (irq_req) begin
                        state_d = StIrqDrain;
                        drain_d = DrainLoad;
                        epc_d   = 1'b0;
                    end
                end
            end

            StMemWait: begin
                if (ext_stall) begin
                    PC_hold   = 1'b1;
                    IFID_hold = 1'b1;
                end else begin
                    state_d = StRun;
                end
            end

            StIrqDrain: begin
                PC_hold   = 1'b1;
                IFID_hold = 1'b1;
                if (!ext_stall) begin
                    IDEX_flush = 1'b1;
                    IFID_flush = EX_Branch_EN;
                end
                // A withdrawn request abandons the entry; no acknowledge is given.
                if (!irq_req) begin
                    state_d = StRun;
                    drain_d = '0;
                    epc_d   = 1'b0;
                end else if (!ext_stall) begin
                    if (EX_Branch_EN) begin
                        epc_d = 1'b1;
                    end
                    if (drain_q <= DrainCntW'(1)) begin
                        drain_d = '0;
                        state_d = StIrqTake;
                    end else begin
                        drain_d = drain_q - 1'b1;
                    end
                end
            end

            StIrqTake: begin
                IFID_flush = 1'b1;
                irq_take   = 1'b1;
                epc_d      = 1'b0;
                state_d    = StRun;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StRun;
            drain_q <= '0;
            epc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            epc_q   <= epc_d;
        end
    end

    assign irq_ack         = IrqEn && irq_take;
    assign PC_irq_sel      = IrqEn && irq_take;
    assign EPC_from_branch = IrqEn && epc_q;
    assign ctrl_state      = state_q;

    sat_counter #(
        .Width(CNT_W)
    ) u_stall_cnt (
        .clk_i (clk),
        .rst_ni(reset),
        .en_i  (PC_hold),
        .cnt_o (stall_cnt)
    );

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 2, number of bubble cycles inserted before an interrupt is taken (range 1..7).
REQ-002 SHALL have parameter CNT_W, default 16, width of the stall performance counter.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port ID_rs, ID_rt  in  5 each  source register numbers of the instruction in ID.
REQ-006 SHALL have port EX_MemRead  in  1  instruction in EX is a load.
REQ-007 SHALL have port EX_rt  in  5  destination register of the EX load.
REQ-008 SHALL have port EX_Branch_EN  in  1  branch resolved taken in EX.
REQ-009 SHALL have port ext_stall  in  1  memory system busy; freeze whole front end.
REQ-010 SHALL have port irq  in  1  level-sensitive external interrupt request.
REQ-011 SHALL have port PC_hold, IFID_hold  out  1 each  keep PC and IF/ID register contents.
REQ-012 SHALL have port IFID_flush, IDEX_flush  out  1 each  load bubble into IF/ID and ID/EX respectively.
REQ-013 SHALL have port irq_ack, PC_irq_sel, EPC_from_branch  out  1 each  interrupt accept, select handler PC, EPC source is branch target.
REQ-014 SHALL have port stall_cnt  out  CNT_W  count of cycles with PC_hold high.
REQ-015 SHALL have port ctrl_state  out  2  current FSM state encoding.

Function
REQ-016 SHALL implement FSM states RUN=0, MEM_WAIT=1, IRQ_DRAIN=2, IRQ_TAKE=3.
REQ-017 SHALL, in RUN, detect load-use: EX_MemRead and EX_rt!=0 and (EX_rt==ID_rs or EX_rt==ID_rt); same cycle (combinational) assert PC_hold, IFID_hold, IDEX_flush; state stays RUN.
REQ-018 SHALL, in RUN, on EX_Branch_EN assert IFID_flush and IDEX_flush same cycle, PC_hold low; branch overrides load-use.
REQ-019 SHALL, in any state except IRQ_TAKE, on ext_stall high assert PC_hold and IFID_hold, suppress all flushes; from RUN enter MEM_WAIT next cycle.
REQ-020 SHALL leave MEM_WAIT to the state saved on entry (RUN) on the first cycle ext_stall is low; interrupt sampling suspended in MEM_WAIT.
REQ-021 SHALL, in RUN with irq high and ext_stall low, enter IRQ_DRAIN next cycle and load drain counter with DRAIN_CYCLES.
REQ-022 SHALL, in IRQ_DRAIN, assert PC_hold, IFID_hold, IDEX_flush each cycle and decrement counter; ext_stall freezes counter.
REQ-023 SHALL, in IRQ_DRAIN, on EX_Branch_EN set EPC_from_branch (sticky until IRQ_TAKE exits) and assert IFID_flush.
REQ-024 SHALL enter IRQ_TAKE when counter reaches 0; IRQ_TAKE lasts exactly one cycle asserting irq_ack, PC_irq_sel, IFID_flush; then RUN.
REQ-025 SHALL return to RUN from IRQ_DRAIN without irq_ack if irq drops before counter reaches 0.
REQ-026 SHALL increment stall_cnt each cycle PC_hold is high, saturating at all-ones.
REQ-027 SHALL drive ctrl_state from the state register; all other outputs combinational from state and inputs.

Reset
REQ-028 SHALL, on reset low, asynchronously force state RUN, drain counter 0, EPC_from_branch 0, stall_cnt 0.
REQ-029 SHALL drive all outputs 0 while in reset absent hazard inputs; reset mid-IRQ_DRAIN drops the pending interrupt without irq_ack.

Configuration
REQ-030 SHALL honour macro PIPE_HAZARD_CTRL_IRQ_EN: defined -> interrupt path per REQ-021..025; undefined -> IRQ_DRAIN/IRQ_TAKE unreachable, irq ignored, irq_ack, PC_irq_sel, EPC_from_branch tied 0.

Structure
REQ-031 SHALL place state encodings and DRAIN_CYCLES default in shared package pipe_ctrl_pkg.
REQ-032 SHALL implement stall counter as sub-module sat_counter (width param, enable, async active-low reset).

Verification
REQ-033 SHALL cover load-use: EX_MemRead=1, EX_rt=5, ID_rs=5 -> PC_hold=IFID_hold=IDEX_flush=1 one cycle; EX_rt=0 -> no stall.
REQ-034 SHALL cover branch plus load-use same cycle -> IFID_flush=IDEX_flush=1, PC_hold=0.
REQ-035 SHALL cover ext_stall high 3 cycles from RUN -> ctrl_state=1 for 3 cycles, no flushes, return to 0, stall_cnt=3.
REQ-036 SHALL cover irq with DRAIN_CYCLES=2 -> states 2,2,3,0; irq_ack high exactly one cycle; branch during drain -> EPC_from_branch=1 at ack.
REQ-037 SHALL cover reset asserted in IRQ_DRAIN -> state 0, no irq_ack; stall_cnt saturation with CNT_W=4 -> holds 15.
